// File: rtl/stage_skid_buffer.sv
// stage_skid_buffer: pipeline stage with registered valid/ready, one-entry skid,
// synchronous squash and a saturating stall counter.
module stage_skid_buffer #(
    parameter int WIDTH       = 16,
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   squash,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_count,
    input  logic                   stall_clr
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] MAIN  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state, state_d;
    logic [WIDTH-1:0] skid, skid_d, data_d;
    logic             accept, drain, stall;

    // handshake flags come from registered state only, so out_ready never reaches in_ready
    assign out_valid = state != EMPTY;
    assign in_ready  = state != FULL;
    assign occupancy = state;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign stall     = out_valid && !out_ready;

    always_comb begin
        state_d = state;
        data_d  = out_data;
        skid_d  = skid;
        if (squash) begin
            state_d = EMPTY;
            data_d  = '0;
            skid_d  = '0;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_d = MAIN;
                    data_d  = in_data;
                end
                MAIN: if (accept && drain) begin
                    data_d = in_data;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (drain) begin
                    state_d = EMPTY;
                end
                FULL: if (drain) begin
                    state_d = MAIN;
                    data_d  = skid;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge flush) begin
        if (flush) begin
            state       <= EMPTY;
            out_data    <= '0;
            skid        <= '0;
            stall_count <= '0;
        end else begin
            state       <= state_d;
            out_data    <= data_d;
            skid        <= skid_d;
            stall_count <= stall_clr ? '0 :
                           (stall && stall_count != '1) ? stall_count + STALL_CNT_W'(1) :
                           stall_count;
        end
    end
endmodule

// File: tb/tb_stage_skid_buffer.sv
// tb_stage_skid_buffer: vector table, directed corner sequences and random traffic
// checked against a queue-based model of the stage.
module tb_stage_skid_buffer;
    logic        clk = 0;
    logic        flush = 1;
    logic [15:0] in_data = '0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 0;
    logic        squash = 0;
    logic [1:0]  occupancy;
    logic [3:0]  stall_count;
    logic        stall_clr = 0;

    stage_skid_buffer #(.WIDTH(16), .STALL_CNT_W(4)) dut (
        .clk(clk), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .squash(squash), .occupancy(occupancy),
        .stall_count(stall_count), .stall_clr(stall_clr)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // model: FIFO of held entries, last presented word, saturating stall count
    logic [15:0] q[$];
    logic [15:0] od = '0;
    int          sc = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    function automatic void check_model();
        chk("occupancy", 32'(occupancy), q.size());
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_data", 32'(out_data), 32'(od));
        chk("stall_count", 32'(stall_count), sc);
    endfunction

    task automatic step(input logic iv, input logic [15:0] d, input logic ordy,
                        input logic sq, input logic clr);
        bit acc, drn, stl;
        in_valid = iv; in_data = d; out_ready = ordy; squash = sq; stall_clr = clr;
        acc = iv && q.size() < 2;
        drn = q.size() > 0 && ordy;
        stl = q.size() > 0 && !ordy;
        if (sq) begin
            q.delete();
            od = '0;
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(d);
            if (q.size() > 0) od = q[0];
        end
        if (clr) sc = 0;
        else if (stl && sc < 15) sc++;
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic        sq;
        logic [1:0]  occ;
        logic [15:0] data;
        logic        ir;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1, 16'h00A1, 0, 0, 2'd1, 16'h00A1, 1};
        vecs[1]  = '{1, 16'h00A2, 0, 0, 2'd2, 16'h00A1, 0};
        vecs[2]  = '{0, 16'h0000, 0, 0, 2'd2, 16'h00A1, 0};
        vecs[3]  = '{1, 16'h00FF, 0, 0, 2'd2, 16'h00A1, 0};
        vecs[4]  = '{0, 16'h0000, 0, 0, 2'd2, 16'h00A1, 0};
        vecs[5]  = '{0, 16'h0000, 1, 0, 2'd1, 16'h00A2, 1};
        vecs[6]  = '{0, 16'h0000, 1, 0, 2'd0, 16'h00A2, 1};
        vecs[7]  = '{1, 16'h00B1, 0, 0, 2'd1, 16'h00B1, 1};
        vecs[8]  = '{1, 16'h00B2, 1, 0, 2'd1, 16'h00B2, 1};
        vecs[9]  = '{0, 16'h0000, 1, 0, 2'd0, 16'h00B2, 1};
        vecs[10] = '{1, 16'h1111, 0, 0, 2'd1, 16'h1111, 1};
        vecs[11] = '{1, 16'h2222, 0, 0, 2'd2, 16'h1111, 0};
        vecs[12] = '{1, 16'h3333, 0, 1, 2'd0, 16'h0000, 1};
        vecs[13] = '{0, 16'h0000, 1, 0, 2'd0, 16'h0000, 1};

        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_stall_count", 32'(stall_count), 0);
        #4 flush = 0;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].sq, 0);
            chk($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(vecs[i].occ));
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].data));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
        end

        for (int i = 1; i <= 8; i++) begin
            step(1, 16'(i), 1, 0, 0);
            chk("stream_data", 32'(out_data), i);
            chk("stream_occ", 32'(occupancy), 1);
        end
        step(0, 0, 1, 0, 0);
        chk("stream_end_occ", 32'(occupancy), 0);

        step(0, 0, 0, 0, 1);
        step(1, 16'h5A5A, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
        chk("stall_saturated", 32'(stall_count), 15);
        step(0, 0, 0, 0, 1);
        chk("stall_clr", 32'(stall_count), 0);
        step(0, 0, 0, 0, 0);
        chk("stall_after_clr", 32'(stall_count), 1);
        step(0, 0, 1, 0, 0);

        step(1, 16'hAAAA, 0, 0, 0);
        step(1, 16'hBBBB, 0, 0, 0);
        chk("pre_flush_occ", 32'(occupancy), 2);
        #2 flush = 1;
        #1;
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        chk("flush_occ", 32'(occupancy), 0);
        chk("flush_out_data", 32'(out_data), 0);
        chk("flush_stall_count", 32'(stall_count), 0);
        q.delete();
        od = '0;
        sc = 0;
        #1 flush = 0;
        step(1, 16'hC0DE, 0, 0, 0);
        chk("post_flush_data", 32'(out_data), 32'h0000C0DE);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
